mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between instruction fetch (F stage) and load/store (M stage).

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter_starve_ctr.sv | 33 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
//   arb_state_t    : arbiter FSM states (IDLE -> REQ -> WAIT -> IDLE)
//   owner_t        : which pipeline stage owns the outstanding transaction
//   STARVE_MAX_DEF : default number of consecutive data wins while fetch waits
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake/bus signal around the arbiter.
//   Fetch side : InstrReqF, PCF, FlushF -> InstrValidF, InstrRdataF, StallF
//   Data side  : DataReqM, DataWeM, DataAddrM, DataWdataM, DataBeM
//                -> DataValidM, DataRdataM, StallM
//   Memory side: MemReq, MemWe, MemAddr, MemWdata, MemBe -> MemGnt, MemRvalid, MemRdata
// Modport slave is the arbiter's view; modport master is the view of the
// surrounding pipeline plus memory that drives the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  InstrReqF;
  logic [ADDR_W-1:0]     PCF;
  logic                  FlushF;
  logic                  InstrValidF;
  logic [DATA_W-1:0]     InstrRdataF;
  logic                  StallF;

  logic                  DataReqM;
  logic                  DataWeM;
  logic [ADDR_W-1:0]     DataAddrM;
  logic [DATA_W-1:0]     DataWdataM;
  logic [DATA_W/8-1:0]   DataBeM;
  logic                  DataValidM;
  logic [DATA_W-1:0]     DataRdataM;
  logic                  StallM;

  logic                  MemReq;
  logic                  MemWe;
  logic [ADDR_W-1:0]     MemAddr;
  logic [DATA_W-1:0]     MemWdata;
  logic [DATA_W/8-1:0]   MemBe;
  logic                  MemGnt;
  logic                  MemRvalid;
  logic [DATA_W-1:0]     MemRdata;

  modport slave (
    input  InstrReqF, PCF, FlushF,
    output InstrValidF, InstrRdataF, StallF,
    input  DataReqM, DataWeM, DataAddrM, DataWdataM, DataBeM,
    output DataValidM, DataRdataM, StallM,
    output MemReq, MemWe, MemAddr, MemWdata, MemBe,
    input  MemGnt, MemRvalid, MemRdata
  );

  modport master (
    output InstrReqF, PCF, FlushF,
    input  InstrValidF, InstrRdataF, StallF,
    output DataReqM, DataWeM, DataAddrM, DataWdataM, DataBeM,
    input  DataValidM, DataRdataM, StallM,
    input  MemReq, MemWe, MemAddr, MemWdata, MemBe,
    output MemGnt, MemRvalid, MemRdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating fetch-starvation counter.
//   clk, reset : clock and synchronous active-high reset
//   inc        : count one more data win (saturates at MAX)
//   clr        : return to zero (wins over inc)
//   at_max     : counter has reached MAX, fetch must be served next
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (F)
// and load/store (M). One transaction is outstanding at a time; its
// response is steered back to the owning stage, the losing stage stalls,
// and responses of flushed fetches are swallowed.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mem_port_arbiter_if.slave carrying the fetch, data and
//                memory handshakes (Mem* outputs are registered; Valid,
//                Rdata and Stall outputs are combinational)
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t           state;
  owner_t               owner;
  logic                 cancel;

  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [BE_W-1:0]      mem_be;

  logic                 at_max;
  logic                 pick_dm;
  logic                 pick_if;
  logic                 st_inc;
  logic                 st_clr;
  logic                 rsp_fire;

  // Data wins unless fetch has already lost STARVE_MAX times in a row.
  always_comb begin
    pick_dm = bus.DataReqM && !(bus.InstrReqF && at_max);
    pick_if = !pick_dm && bus.InstrReqF;
    st_inc  = (state == IDLE) && pick_dm && bus.InstrReqF;
    st_clr  = (state == IDLE) && (pick_if || !bus.InstrReqF);
  end

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (st_inc),
    .clr    (st_clr),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      cancel    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cancel <= 1'b0;
          if (pick_dm) begin
            owner     <= OWN_DM;
            mem_req   <= 1'b1;
            mem_we    <= bus.DataWeM;
            mem_addr  <= bus.DataAddrM;
            mem_wdata <= bus.DataWdataM;
            mem_be    <= bus.DataBeM;
            state     <= REQ;
          end else if (pick_if) begin
            owner     <= OWN_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= bus.PCF;
            mem_wdata <= '0;
            mem_be    <= '1;
            state     <= REQ;
          end
        end
        REQ: begin
          if ((owner == OWN_IF) && bus.FlushF) begin
            cancel <= 1'b1;
          end
          // A response before the grant cannot belong to us; ignore it.
          if (bus.MemGnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if ((owner == OWN_IF) && bus.FlushF) begin
            cancel <= 1'b1;
          end
          if (bus.MemRvalid) begin
            owner  <= OWN_NONE;
            cancel <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Gating with reset keeps a response arriving during reset from
  // escaping as a Valid pulse.
  assign rsp_fire = !reset && (state == WAIT) && bus.MemRvalid;

  // A flush in the completion cycle itself also kills the fetch response.
  assign bus.InstrValidF = rsp_fire && (owner == OWN_IF) && !cancel && !bus.FlushF;
  assign bus.DataValidM  = rsp_fire && (owner == OWN_DM);
  assign bus.InstrRdataF = bus.MemRdata;
  assign bus.DataRdataM  = bus.MemRdata;
  assign bus.StallF      = bus.InstrReqF & ~bus.InstrValidF;
  assign bus.StallM      = bus.DataReqM & ~bus.DataValidM;

  assign bus.MemReq   = mem_req;
  assign bus.MemWe    = mem_we;
  assign bus.MemAddr  = mem_addr;
  assign bus.MemWdata = mem_wdata;
  assign bus.MemBe    = mem_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Expected memory
// requests and expected responses are queued as stimulus is driven and
// popped as the memory side is served.
module tb_mem_port_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_exp_t;

  typedef struct {
    int          owner;   // 1 = fetch, 2 = data
    logic [31:0] rdata;
    bit          vld;     // 0 = response must be suppressed
  } rsp_exp_t;

  logic clk;
  logic reset;
  int   ncmp;
  int   nerr;

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] pc, input logic [31:0] rd, input bit vld);
    mem_exp_t m;
    rsp_exp_t r;
    m.we = 1'b0; m.addr = pc; m.wdata = 32'h0; m.be = 4'hF;
    r.owner = 1; r.rdata = rd; r.vld = vld;
    mem_q.push_back(m);
    rsp_q.push_back(r);
  endtask

  task automatic push_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input logic [31:0] rd, input bit vld);
    mem_exp_t m;
    rsp_exp_t r;
    m.we = we; m.addr = a; m.wdata = wd; m.be = be;
    r.owner = 2; r.rdata = rd; r.vld = vld;
    mem_q.push_back(m);
    rsp_q.push_back(r);
  endtask

  // Plays the memory for one transaction. Called at a negedge right after
  // the requests are driven; returns at the negedge of the IDLE bubble.
  task automatic serve(input int gnt_dly, input int rv_dly, input int flush_at,
                       input bit spur, input logic [31:0] rd, output int lat);
    mem_exp_t em;
    rsp_exp_t er;
    bit       fv;
    bit       dv;
    lat = 0;
    while (bus.MemReq !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    em = mem_q.pop_front();
    er = rsp_q.pop_front();
    if (bus.MemReq !== 1'b1) begin
      chk("mem_req_timeout", bus.MemReq, 1'b1);
      return;
    end
    chk("mem_we", bus.MemWe, em.we);
    chk("mem_addr", bus.MemAddr, em.addr);
    chk("mem_be", bus.MemBe, em.be);
    if (em.we) chk("mem_wdata", bus.MemWdata, em.wdata);
    for (int i = 0; i < gnt_dly; i++) begin
      bus.MemGnt = 1'b0;
      bus.MemRvalid = spur && (i == 0);
      #1;
      chk("req_hold", bus.MemReq, 1'b1);
      chk("req_addr_stable", bus.MemAddr, em.addr);
      chk("req_no_ivalid", bus.InstrValidF, 1'b0);
      chk("req_no_dvalid", bus.DataValidM, 1'b0);
      chk("req_stallf", bus.StallF, bus.InstrReqF);
      chk("req_stallm", bus.StallM, bus.DataReqM);
      @(negedge clk);
    end
    bus.MemRvalid = 1'b0;
    bus.MemGnt = 1'b1;
    bus.FlushF = (flush_at == 0);
    #1;
    chk("gnt_req", bus.MemReq, 1'b1);
    @(negedge clk);
    bus.MemGnt = 1'b0;
    for (int i = 1; i < rv_dly; i++) begin
      bus.FlushF = (i == flush_at);
      #1;
      chk("wait_req_low", bus.MemReq, 1'b0);
      chk("wait_no_ivalid", bus.InstrValidF, 1'b0);
      chk("wait_no_dvalid", bus.DataValidM, 1'b0);
      @(negedge clk);
    end
    bus.FlushF = (flush_at == rv_dly);
    bus.MemRvalid = 1'b1;
    bus.MemRdata = rd;
    #1;
    fv = (er.owner == 1) && er.vld;
    dv = (er.owner == 2) && er.vld;
    chk("instr_valid", bus.InstrValidF, fv);
    chk("data_valid", bus.DataValidM, dv);
    if (fv) chk("instr_rdata", bus.InstrRdataF, er.rdata);
    if (dv) chk("data_rdata", bus.DataRdataM, er.rdata);
    chk("rsp_stallf", bus.StallF, bus.InstrReqF && !fv);
    chk("rsp_stallm", bus.StallM, bus.DataReqM && !dv);
    @(negedge clk);
    bus.MemRvalid = 1'b0;
    bus.FlushF = 1'b0;
    bus.MemRdata = 32'h0;
  endtask

  initial begin
    int lat;
    ncmp = 0;
    nerr = 0;
    reset = 1'b1;
    bus.InstrReqF = 1'b0; bus.PCF = 32'h0; bus.FlushF = 1'b0;
    bus.DataReqM = 1'b0; bus.DataWeM = 1'b0; bus.DataAddrM = 32'h0;
    bus.DataWdataM = 32'h0; bus.DataBeM = 4'h0;
    bus.MemGnt = 1'b0; bus.MemRvalid = 1'b0; bus.MemRdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mem_req", bus.MemReq, 1'b0);
    chk("rst_mem_we", bus.MemWe, 1'b0);
    chk("rst_mem_addr", bus.MemAddr, 32'h0);
    chk("rst_mem_wdata", bus.MemWdata, 32'h0);
    chk("rst_mem_be", bus.MemBe, 4'h0);
    chk("rst_ivalid", bus.InstrValidF, 1'b0);
    chk("rst_dvalid", bus.DataValidM, 1'b0);
    @(negedge clk);

    // Single fetch, immediate grant, response one cycle later.
    push_fetch(32'h100, 32'h00500093, 1'b1);
    bus.InstrReqF = 1'b1; bus.PCF = 32'h100;
    serve(0, 1, -1, 1'b0, 32'h00500093, lat);
    chk("fetch_latency", lat, 1);
    bus.InstrReqF = 1'b0;
    @(negedge clk);

    // Store and fetch together: store first, fetch after the bubble.
    push_data(1'b1, 32'h2000, 32'hDEADBEEF, 4'h3, 32'h0, 1'b1);
    push_fetch(32'h104, 32'h00A00113, 1'b1);
    bus.InstrReqF = 1'b1; bus.PCF = 32'h104;
    bus.DataReqM = 1'b1; bus.DataWeM = 1'b1; bus.DataAddrM = 32'h2000;
    bus.DataWdataM = 32'hDEADBEEF; bus.DataBeM = 4'h3;
    #1;
    chk("both_stallf", bus.StallF, 1'b1);
    serve(0, 1, -1, 1'b0, 32'h0, lat);
    bus.DataReqM = 1'b0; bus.DataWeM = 1'b0;
    serve(0, 1, -1, 1'b0, 32'h00A00113, lat);
    chk("fetch_after_bubble_lat", lat, 1);
    bus.InstrReqF = 1'b0;
    @(negedge clk);

    // Starvation: continuous loads with fetch waiting.
    bus.InstrReqF = 1'b1; bus.PCF = 32'h600;
    bus.DataReqM = 1'b1; bus.DataWeM = 1'b0; bus.DataAddrM = 32'h3000;
    bus.DataWdataM = 32'h0; bus.DataBeM = 4'hF;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        push_data(1'b0, 32'h3000, 32'h0, 4'hF, 32'h1000 + k, 1'b1);
        serve(0, 1, -1, 1'b0, 32'h1000 + k, lat);
        chk("starve_data_lat", lat, 1);
      end
      push_fetch(32'h600, 32'h00000013, 1'b1);
      serve(0, 1, -1, 1'b0, 32'h00000013, lat);
      chk("starve_fetch_lat", lat, 1);
    end
    bus.InstrReqF = 1'b0;
    push_data(1'b0, 32'h3000, 32'h0, 4'hF, 32'h2222, 1'b1);
    serve(0, 1, -1, 1'b0, 32'h2222, lat);
    bus.DataReqM = 1'b0;
    @(negedge clk);

    // Flush in fetch WAIT; response three cycles later is dropped.
    push_fetch(32'h200, 32'h11111111, 1'b0);
    bus.InstrReqF = 1'b1; bus.PCF = 32'h200;
    serve(0, 4, 1, 1'b0, 32'h11111111, lat);
    push_fetch(32'h204, 32'h22222222, 1'b1);
    bus.PCF = 32'h204;
    serve(0, 1, -1, 1'b0, 32'h22222222, lat);
    chk("post_flush_lat", lat, 1);
    bus.InstrReqF = 1'b0;
    @(negedge clk);

    // Flush in the same cycle as the fetch response.
    push_fetch(32'h300, 32'h33333333, 1'b0);
    bus.InstrReqF = 1'b1; bus.PCF = 32'h300;
    serve(0, 2, 2, 1'b0, 32'h33333333, lat);
    bus.InstrReqF = 1'b0;
    @(negedge clk);

    // Flush during a store is ignored.
    push_data(1'b1, 32'h2100, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1);
    bus.DataReqM = 1'b1; bus.DataWeM = 1'b1; bus.DataAddrM = 32'h2100;
    bus.DataWdataM = 32'hCAFEF00D; bus.DataBeM = 4'hF;
    serve(0, 2, 1, 1'b0, 32'h0, lat);
    bus.DataReqM = 1'b0; bus.DataWeM = 1'b0;
    @(negedge clk);

    // Grant delayed 5 cycles with a spurious response during REQ.
    push_data(1'b0, 32'h4000, 32'h0, 4'hC, 32'h5A5A0000, 1'b1);
    bus.DataReqM = 1'b1; bus.DataAddrM = 32'h4000; bus.DataBeM = 4'hC;
    serve(5, 1, -1, 1'b1, 32'h5A5A0000, lat);
    bus.DataReqM = 1'b0;
    @(negedge clk);

    // Reset in WAIT, late response afterwards.
    bus.InstrReqF = 1'b1; bus.PCF = 32'h500;
    lat = 0;
    while (bus.MemReq !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("rst_test_req", bus.MemReq, 1'b1);
    bus.MemGnt = 1'b1;
    @(negedge clk);
    bus.MemGnt = 1'b0;
    reset = 1'b1;
    bus.InstrReqF = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.MemRvalid = 1'b1;
    bus.MemRdata = 32'h77777777;
    #1;
    chk("late_ivalid", bus.InstrValidF, 1'b0);
    chk("late_dvalid", bus.DataValidM, 1'b0);
    chk("late_mem_req", bus.MemReq, 1'b0);
    chk("late_mem_addr", bus.MemAddr, 32'h0);
    chk("late_mem_be", bus.MemBe, 4'h0);
    chk("late_mem_we", bus.MemWe, 1'b0);
    chk("late_stallf", bus.StallF, 1'b0);
    @(negedge clk);
    bus.MemRvalid = 1'b0;
    bus.MemRdata = 32'h0;
    push_fetch(32'h504, 32'h44444444, 1'b1);
    bus.InstrReqF = 1'b1; bus.PCF = 32'h504;
    serve(0, 1, -1, 1'b0, 32'h44444444, lat);
    chk("post_reset_lat", lat, 1);
    bus.InstrReqF = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
